dbg_reg_reader: RTL and testbench
=================================

DBG_REG_READER -- requirements
Module: dbg_reg_reader

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers dumped.
REQ-002 SHALL have parameter AWIDTH, default 5, debug address width.
REQ-003 SHALL have parameter DWIDTH, default 32, register width; a multiple of 8.
REQ-004 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-005 CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 RSTn  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  single-cycle dump request.
REQ-008 o_dbg_run  output  1  CPU run enable; 1 = run, 0 = halted for dump.
REQ-009 o_dbg_addr  output  AWIDTH  register-file debug read address.
REQ-010 i_dbg_reg  input  DWIDTH  asynchronous register-file debug read data.
REQ-011 o_tx_data  output  8  byte toward the UART transmitter.
REQ-012 o_tx_valid  output  1  o_tx_data is valid.
REQ-013 i_tx_ready  input  1  UART transmitter accepts the byte.
REQ-014 o_busy  output  1  dump in progress.
REQ-015 o_done  output  1  one-cycle pulse when the final byte is accepted.

Function
REQ-016 SHALL implement states IDLE, HALT, HEADER, LATCH, SEND, NEXT, DONE.
REQ-017 IDLE: o_dbg_run=1, o_busy=0; i_start=1 -> HALT.
REQ-018 HALT: o_dbg_run=0, o_dbg_addr=0; lasts exactly 1 cycle, so any in-flight register write retires -> HEADER.
REQ-019 HEADER: drive HDR with o_tx_valid=1 until accepted -> LATCH.
REQ-020 A byte SHALL be accepted on a rising edge where o_tx_valid=1 and i_tx_ready=1.
REQ-021 o_tx_data SHALL stay stable, and o_tx_valid SHALL not drop, until the byte is accepted.
REQ-022 LATCH: capture i_dbg_reg into a DWIDTH shift register in 1 cycle -> SEND.
REQ-023 SEND: emit DWIDTH/8 bytes LSB first, shifting right 8 bits per accepted byte; after the last byte -> NEXT.
REQ-024 NEXT: if o_dbg_addr == NREGS-1 -> DONE, else increment o_dbg_addr -> LATCH.
REQ-025 DONE: o_done=1 for 1 cycle, o_dbg_run returns to 1, o_dbg_addr resets to 0 -> IDLE.
REQ-026 Frame length SHALL be 1 + NREGS*DWIDTH/8 bytes (129 with defaults).
REQ-027 o_dbg_run SHALL be 0 in every state except IDLE and DONE.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 i_start SHALL be ignored outside IDLE.
REQ-030 i_tx_ready SHALL be ignored while o_tx_valid=0.
REQ-031 Address 0 SHALL be dumped as whatever i_dbg_reg returns; no special casing.
REQ-032 The byte counter SHALL be ceil(log2(DWIDTH/8)) bits wide and SHALL not wrap mid-register.
REQ-033 i_tx_ready held low indefinitely SHALL stall the dump with all outputs frozen; no timeout.

Reset
REQ-034 RSTn=0 SHALL force IDLE immediately, including mid-dump.
REQ-035 Reset values: o_dbg_run=1, o_dbg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, shift register=0.
REQ-036 A dump aborted by reset SHALL not resume; a new i_start is required.

Structure
REQ-037 State encodings and HDR default SHALL live in the shared debug package alongside the UART constants.
REQ-038 SHALL be a single module with no sub-modules; the byte serializer is inline.
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 Regfile model RF[n]=32'h1000_0000+n, i_tx_ready=1, pulse i_start -> 129 bytes: A5, 00 00 00 10, 01 00 00 10, ..., 1F 00 00 10; o_done is pulsed once.
REQ-041 Same frame with i_tx_ready toggling every 3 cycles -> identical byte sequence with no duplicated or dropped bytes; data is stable while stalled.
REQ-042 i_start pulsed again during the dump -> ignored; exactly 129 bytes are sent.
REQ-043 RSTn low after the 40th accepted byte -> o_tx_valid=0 and o_dbg_run=1 immediately; the next i_start restarts at A5.
REQ-044 o_dbg_run=0 from the HALT cycle through the last byte, and 1 in the DONE cycle; the regfile model write attempted while halted does not change the dumped value.

Source files
------------

// File: rtl/dbg_reg_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_reg_reader_pkg
// Description : Shared debug package. Holds the register-dump FSM state
//               encodings, the default frame header byte and the UART
//               framing constants used by the debug path.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_reg_reader_pkg;

    // Register-dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_HEADER = 3'd2,
        ST_LATCH  = 3'd3,
        ST_SEND   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } dbg_state_e;

    // Frame header byte that opens every register dump
    localparam logic [7:0] c_DBG_HDR_DEFAULT = 8'hA5;

    // UART framing constants shared with the transmitter
    localparam int c_UART_DATA_BITS    = 8;
    localparam int c_UART_STOP_BITS    = 1;
    localparam int c_UART_CLKS_PER_BIT = 868;

    // Width of a counter indexing nbytes bytes; never narrower than 1 bit
    function automatic int bcnt_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage : dbg_reg_reader_pkg
`default_nettype wire

// File: rtl/dbg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : dbg_reg_reader
// Description : Halts the CPU, walks the register file through its debug
//               read port and streams a header byte followed by every
//               register (LSB first) to a UART transmitter over a
//               valid/ready byte handshake. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_reg_reader
    import dbg_reg_reader_pkg::*;
#(
    parameter int         NREGS  = 32,
    parameter int         AWIDTH = 5,
    parameter int         DWIDTH = 32,
    parameter logic [7:0] HDR    = c_DBG_HDR_DEFAULT
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_start,
    output logic              o_dbg_run,
    output logic [AWIDTH-1:0] o_dbg_addr,
    input  logic [DWIDTH-1:0] i_dbg_reg,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                 c_NBYTES    = DWIDTH / 8;
    localparam int                 c_BCNT_W    = bcnt_width(c_NBYTES);
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(c_NBYTES - 1);
    localparam logic [AWIDTH-1:0]   c_LAST_ADDR = AWIDTH'(NREGS - 1);

    dbg_state_e          r_state;
    logic                r_dbg_run;
    logic [AWIDTH-1:0]   r_dbg_addr;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_busy;
    logic                r_done;
    logic [DWIDTH-1:0]   r_shreg;
    logic [c_BCNT_W-1:0] r_bcnt;

    logic                w_accept;
    logic                w_last_byte;
    logic [DWIDTH-1:0]   w_shreg_nxt;

    // A byte only counts as taken while we are actually offering one
    assign w_accept    = r_tx_valid & i_tx_ready;
    assign w_last_byte = (r_bcnt == c_LAST_BYTE);

    // Next shift-register value: load on LATCH, shift one byte per accepted non-final byte
    always_comb begin
        w_shreg_nxt = r_shreg;
        if (r_state == ST_LATCH) begin
            w_shreg_nxt = i_dbg_reg;
        end else if (r_state == ST_SEND && w_accept && !w_last_byte) begin
            w_shreg_nxt = r_shreg >> 8;
        end
    end

    // Dump sequencer with registered outputs; the next byte is loaded alongside the state change
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_dbg_run  <= 1'b1;
            r_dbg_addr <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shreg    <= '0;
            r_bcnt     <= '0;
        end else begin
            r_shreg <= w_shreg_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= ST_HALT;
                        r_dbg_run  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dbg_addr <= '0;
                    end
                end
                // One dead cycle so a write already in the CPU pipeline lands first
                ST_HALT: begin
                    r_state    <= ST_HEADER;
                    r_tx_data  <= HDR;
                    r_tx_valid <= 1'b1;
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        r_state    <= ST_LATCH;
                        r_tx_valid <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    r_state    <= ST_SEND;
                    r_tx_data  <= w_shreg_nxt[7:0];
                    r_tx_valid <= 1'b1;
                    r_bcnt     <= '0;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            r_state    <= ST_NEXT;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data <= w_shreg_nxt[7:0];
                            r_bcnt    <= r_bcnt + c_BCNT_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_dbg_addr == c_LAST_ADDR) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_dbg_run  <= 1'b1;
                        r_dbg_addr <= '0;
                    end else begin
                        r_state    <= ST_LATCH;
                        r_dbg_addr <= r_dbg_addr + AWIDTH'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dbg_run  <= 1'b1;
                    r_dbg_addr <= '0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_run  = r_dbg_run;
    assign o_dbg_addr = r_dbg_addr;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule : dbg_reg_reader
`default_nettype wire

// File: tb/tb_dbg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_reg_reader
// Description : Self-checking bench for dbg_reg_reader. A frame model built
//               from the register-file contents predicts every byte; one
//               compare process checks the handshake stream each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_reg_reader;

    localparam int NREGS     = 32;
    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int NB        = DW / 8;
    localparam int FRAME_LEN = 1 + NREGS * NB;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          start;
    logic          dbg_run;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_reg;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [NREGS];
    logic [7:0]    exp_q [$];
    logic [7:0]    rx [$];
    int            done_cnt;
    int            n_chk;
    int            n_pass;
    int            ready_mode;
    int            cyc;
    bit            prev_stall;
    logic [7:0]    prev_data;

    dbg_reg_reader #(
        .NREGS (NREGS),
        .AWIDTH(AW),
        .DWIDTH(DW),
        .HDR   (8'hA5)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .i_start   (start),
        .o_dbg_run (dbg_run),
        .o_dbg_addr(dbg_addr),
        .i_dbg_reg (dbg_reg),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 CLK = ~CLK;

    // Asynchronous register-file debug read port
    always_comb dbg_reg = rf[dbg_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Expected frame: header, then each register low byte first
    task automatic build_frame();
        exp_q.delete();
        rx.delete();
        done_cnt = 0;
        exp_q.push_back(8'hA5);
        for (int n = 0; n < NREGS; n++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back(rf[n][8*b +: 8]);
    endtask

    // CPU-side write: only lands while the CPU is running
    task automatic cpu_try_write(input int idx, input logic [DW-1:0] val);
        if (dbg_run) rf[idx] = val;
    endtask

    task automatic start_pulse(input bit halt_write);
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        check("halt_run_low", dbg_run, 1'b0);
        check("halt_busy", busy, 1'b1);
        check("halt_addr", dbg_addr, '0);
        if (halt_write) cpu_try_write(0, 32'hDEAD_BEEF);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge CLK);
            c++;
        end
        check("done_seen", done, 1'b1);
        repeat (3) @(negedge CLK);
        #1;
        check("frame_len", rx.size(), FRAME_LEN);
        check("left_over", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
        check("idle_after", busy, 1'b0);
    endtask

    // Ready pattern generator: steady, 3-on/3-off, or random
    initial begin
        tx_ready = 1'b0;
        cyc      = 0;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((cyc / 3) % 2) == 0;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    end

    // Per-cycle compare against the frame model
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge CLK);
            if (RSTn !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", tx_valid, 1'b1);
                    check("stall_data", tx_data, prev_data);
                end
                if (busy === 1'b0) begin
                    check("idle_run", dbg_run, 1'b1);
                    check("idle_valid", tx_valid, 1'b0);
                end
                if (tx_valid === 1'b1) check("run_low_sending", dbg_run, 1'b0);
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_byte: got %02h, expected no byte", tx_data);
                    end else begin
                        check($sformatf("byte[%0d]", rx.size()), tx_data, exp_q.pop_front());
                    end
                    rx.push_back(tx_data);
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    check("done_after_last", exp_q.size(), 0);
                    check("done_run", dbg_run, 1'b1);
                end
                prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        int c;
        logic [DW-1:0] wval;
        n_chk = 0; n_pass = 0; done_cnt = 0;
        ready_mode = 0;
        start = 1'b0;
        RSTn  = 1'b1;
        for (int n = 0; n < NREGS; n++) rf[n] = 32'h1000_0000 + n;

        // Reset state
        #2 RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_run", dbg_run, 1'b1);
        check("rst_addr", dbg_addr, '0);
        check("rst_data", tx_data, 8'h00);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge CLK) RSTn = 1'b1;

        // Plain frame, ready always high; literal bytes pin the model
        build_frame();
        start_pulse(1'b0);
        wait_done(5000);
        check("lit_hdr", rx[0], 8'hA5);
        check("lit_r0_b0", rx[1], 8'h00);
        check("lit_r0_b3", rx[4], 8'h10);
        check("lit_r1_b0", rx[5], 8'h01);
        check("lit_r31_b0", rx[125], 8'h1F);
        check("lit_last", rx[128], 8'h10);

        // Ready toggling every 3 cycles
        ready_mode = 1;
        build_frame();
        start_pulse(1'b0);
        wait_done(5000);

        // Second start mid-dump must be ignored
        ready_mode = 0;
        build_frame();
        start_pulse(1'b0);
        repeat (50) @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        wait_done(5000);

        // Reset after the 40th accepted byte, then a clean restart
        build_frame();
        start_pulse(1'b0);
        c = 0;
        while (rx.size() < 40 && c < 2000) begin
            @(negedge CLK); #1;
            c++;
        end
        check("reach_40", rx.size(), 40);
        @(posedge CLK); #1 RSTn = 1'b0;
        #1;
        check("abort_valid", tx_valid, 1'b0);
        check("abort_run", dbg_run, 1'b1);
        check("abort_busy", busy, 1'b0);
        exp_q.delete();
        rx.delete();
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        check("no_resume", busy, 1'b0);
        check("no_resume_done", done_cnt, 0);
        build_frame();
        start_pulse(1'b0);
        wait_done(5000);
        check("restart_hdr", rx[0], 8'hA5);

        // Random register contents, random ready, CPU writes
        ready_mode = 2;
        for (int t = 0; t < 2; t++) begin
            for (int n = 0; n < NREGS; n++) rf[n] = $urandom;
            wval = $urandom;
            cpu_try_write(5, wval);
            check("idle_write_lands", rf[5], wval);
            build_frame();
            start_pulse(1'b1);
            wait_done(8000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dbg_reg_reader
`default_nettype wire
